// File: rtl/id_pkg.sv
// Shared encodings for the ARM decode stage: instruction fields, ALU commands,
// condition codes and status-bit positions.
package id_pkg;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NONE = 4'b0000;
  localparam logic [3:0] EXE_MOV  = 4'b0001;
  localparam logic [3:0] EXE_ADD  = 4'b0010;
  localparam logic [3:0] EXE_ADC  = 4'b0011;
  localparam logic [3:0] EXE_SUB  = 4'b0100;
  localparam logic [3:0] EXE_SBC  = 4'b0101;
  localparam logic [3:0] EXE_AND  = 4'b0110;
  localparam logic [3:0] EXE_ORR  = 4'b0111;
  localparam logic [3:0] EXE_EOR  = 4'b1000;
  localparam logic [3:0] EXE_MVN  = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       b;
    logic       s;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_stage_cond.sv
// ARM condition-field evaluation against the {N,Z,C,V} flags.
module condition_check
  import id_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] status_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign n = status_i[ST_N];
  assign z = status_i[ST_Z];
  assign c = status_i[ST_C];
  assign v = status_i[ST_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_stage_regfile.sv
// R0-R14 register file: two combinational read ports with write-back bypass,
// one write port; index 15 reads as zero and is never written.
module register_file
  import id_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rd_idx_a_i,
  input  logic [3:0]  rd_idx_b_i,
  output logic [31:0] rd_data_a_o,
  output logic [31:0] rd_data_b_o,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_idx_i,
  input  logic [31:0] wr_data_i
);

  logic [31:0] rf_q [0:14];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= 32'(i);
    end else if (wr_en_i && wr_idx_i != REG_PC) begin
      rf_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_a_o = '0;
    if (rd_idx_a_i != REG_PC)
      rd_data_a_o = (wr_en_i && wr_idx_i == rd_idx_a_i) ? wr_data_i : rf_q[rd_idx_a_i];
  end

  always_comb begin
    rd_data_b_o = '0;
    if (rd_idx_b_i != REG_PC)
      rd_data_b_o = (wr_en_i && wr_idx_i == rd_idx_b_i) ? wr_data_i : rf_q[rd_idx_b_i];
  end

endmodule

// File: rtl/id_stage.sv
// ARM instruction-decode stage: register-file read, control decode with
// condition/hazard gating, and hazard-unit source indices.
module id_stage
  import id_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_in,
  input  logic [31:0] Instruction,
  input  logic [3:0]  status,
  input  logic        hazard,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [31:0] PC,
  output logic [31:0] Val_Rn,
  output logic [31:0] Val_Rm,
  output logic [3:0]  exe_cmd,
  output logic        mem_read,
  output logic        mem_write,
  output logic        wb_en_out,
  output logic        B,
  output logic        S,
  output logic        imm,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm_24,
  output logic [3:0]  dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        two_src
);

  logic [1:0] mode;
  logic [3:0] opcode;
  logic       s_bit;
  logic       cond_pass;
  ctrl_t      ctrl_raw;
  ctrl_t      ctrl;

  assign mode   = Instruction[27:26];
  assign opcode = Instruction[24:21];
  assign s_bit  = Instruction[20];

  register_file u_rf (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_a_i  (Instruction[19:16]),
    .rd_idx_b_i  (Instruction[3:0]),
    .rd_data_a_o (Val_Rn),
    .rd_data_b_o (Val_Rm),
    .wr_en_i     (wb_en),
    .wr_idx_i    (wb_dest),
    .wr_data_i   (wb_value)
  );

  condition_check u_cond (
    .cond_i   (Instruction[31:28]),
    .status_i (status),
    .pass_o   (cond_pass)
  );

  always_comb begin
    ctrl_raw = CTRL_NONE;
    case (mode)
      MODE_ARITH: begin
        ctrl_raw.wb_en = 1'b1;
        ctrl_raw.s     = s_bit;
        case (opcode)
          OP_MOV: ctrl_raw.exe_cmd = EXE_MOV;
          OP_MVN: ctrl_raw.exe_cmd = EXE_MVN;
          OP_ADD: ctrl_raw.exe_cmd = EXE_ADD;
          OP_ADC: ctrl_raw.exe_cmd = EXE_ADC;
          OP_SUB: ctrl_raw.exe_cmd = EXE_SUB;
          OP_SBC: ctrl_raw.exe_cmd = EXE_SBC;
          OP_AND: ctrl_raw.exe_cmd = EXE_AND;
          OP_ORR: ctrl_raw.exe_cmd = EXE_ORR;
          OP_EOR: ctrl_raw.exe_cmd = EXE_EOR;
          // Compare/test only set flags: no write-back, S always on
          OP_CMP: begin
            ctrl_raw.exe_cmd = EXE_SUB;
            ctrl_raw.wb_en   = 1'b0;
            ctrl_raw.s       = 1'b1;
          end
          OP_TST: begin
            ctrl_raw.exe_cmd = EXE_AND;
            ctrl_raw.wb_en   = 1'b0;
            ctrl_raw.s       = 1'b1;
          end
          default: ctrl_raw = CTRL_NONE;
        endcase
      end
      MODE_MEM: begin
        ctrl_raw.exe_cmd = EXE_ADD;
        if (s_bit) begin
          ctrl_raw.mem_read = 1'b1;
          ctrl_raw.wb_en    = 1'b1;
        end else begin
          ctrl_raw.mem_write = 1'b1;
        end
      end
      MODE_BRANCH: ctrl_raw.b = 1'b1;
      default:     ctrl_raw = CTRL_NONE;
    endcase
  end

  assign ctrl = (rst || hazard || !cond_pass) ? CTRL_NONE : ctrl_raw;

  assign exe_cmd   = ctrl.exe_cmd;
  assign mem_read  = ctrl.mem_read;
  assign mem_write = ctrl.mem_write;
  assign wb_en_out = ctrl.wb_en;
  assign B         = ctrl.b;
  assign S         = ctrl.s;

  assign PC            = PC_in;
  assign imm           = Instruction[25];
  assign shift_operand = Instruction[11:0];
  assign signed_imm_24 = Instruction[23:0];
  assign dest          = Instruction[15:12];

  // Stores read Rd as data, so the hazard unit must see it as the second source
  assign src1    = Instruction[19:16];
  assign src2    = ctrl_raw.mem_write ? Instruction[15:12] : Instruction[3:0];
  assign two_src = ~Instruction[25] | ctrl_raw.mem_write;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage ARM pipeline. It consumes the fetched instruction word and its PC+4 value, which the IF/ID pipeline register holds. It also holds the architectural register file (R0–R14), written back from the WB stage. It produces operand values, immediates, destination/source indices and gated control signals for the ID/EXE pipeline register, and hazard-detection indices for the hazard unit.

## Interface
Parameters:
- none (all widths fixed by the ARM datapath: 32-bit data, 4-bit register index)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- PC_in  in  32  PC+4 from IF/ID register
- Instruction  in  32  instruction word from IF/ID register
- status  in  4  {N,Z,C,V} from status register
- hazard  in  1  hazard unit request to bubble this instruction
- wb_en  in  1  write-back enable
- wb_dest  in  4  write-back register index
- wb_value  in  32  write-back data
- PC  out  32  PC_in passthrough
- Val_Rn, Val_Rm  out  32  register operands for Instruction[19:16], [3:0]
- exe_cmd  out  4  ALU command
- mem_read, mem_write, wb_en_out, B, S  out  1 each  gated control
- imm  out  1  Instruction[25]
- shift_operand  out  12  Instruction[11:0]
- signed_imm_24  out  24  Instruction[23:0]
- dest  out  4  Instruction[15:12]
- src1, src2  out  4  hazard-check source indices
- two_src  out  1  instruction reads a second register

## Operation
- Register file: 15×32-bit, R0–R14. Read is combinational. Write at rising clk when wb_en=1 and wb_dest≠15. Index 15 reads 0; writes to it are ignored.
- Read bypass: if wb_en=1 and wb_dest equals a read index (≠15) in the same cycle, that port returns wb_value.
- Reset: at rising clk with rst=1, R[i] ← i for i=0..14. rst has priority over a simultaneous write.
- Decode: mode=Instruction[27:26], opcode=Instruction[24:21], S bit=Instruction[20].
  - mode 00 exe_cmd: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110.
  - mode 00 wb_en: 1 for every opcode except CMP and TST.
  - mode 00 S: S bit (forced 1 for CMP, TST).
  - mode 01: exe_cmd=0010. S bit=1 → LDR (mem_read=1, wb_en=1); S bit=0 → STR (mem_write=1). S output=0.
  - mode 10: B=1, all others 0.
  - Unlisted opcode/mode: all control 0, exe_cmd=0000.
- Condition check on Instruction[31:28] vs status, standard ARM: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL=1110 always. 1111 evaluates false.
- Gating: if hazard=1 or condition false, exe_cmd, mem_read, mem_write, wb_en_out, B and S are all 0. Data and index outputs remain unchanged.
- src1=Instruction[19:16]; src2 = mem_write ? Instruction[15:12] : Instruction[3:0]. Uses the ungated mem_write.
- two_src = ~imm | ungated mem_write.

## Timing
- All outputs combinational from inputs and register file state; zero-cycle latency.
- Register write visible through bypass in the same cycle, and from the array on the next cycle.
- While rst=1, all control outputs are forced 0. Registers hold reset values from the first edge with rst=1.
- hazard and condition gating are purely combinational. The register file ignores hazard.

## Structure
- Package id_pkg holds:
  - mode and opcode constants
  - EXE_CMD encodings
  - condition-code constants
  - status bit positions
- Sub-modules:
  - register_file: clk, rst, two read ports with bypass, one write port.
  - condition_check: combinational.
  - The control decoder stays inline.

## Test plan
- Reset: rst=1 for one edge, then Instruction reading Rn=5, Rm=9 → Val_Rn=5, Val_Rm=9.
- ADDS R2,R3,R4 (0xE0932004), status=0 → exe_cmd=0010, S=1, wb_en_out=1, dest=2, two_src=1, src2=4.
- Write and bypass:
  - wb_en=1, wb_dest=3, wb_value=0xDEADBEEF while decoding Rn=3 → Val_Rn=0xDEADBEEF in the same cycle.
  - Next cycle with wb_en=0 → still 0xDEADBEEF.
  - wb_dest=15 → no change; Val reading R15 = 0.
- Condition gating: ADDEQ with status Z=0 → all control 0. With Z=1 → control as decoded. GT with N=V=1, Z=0 → passes.
- STR R1,[R2,#4] (0xE5821004) → mem_write=1, exe_cmd=0010, wb_en_out=0, src2=1, two_src=1. Same with hazard=1 → mem_write=0, src2 still 1.
- B (0xEA000010) → B=1, signed_imm_24=0x000010, wb_en_out=0. Also simultaneous rst and wb_en=1 to R4 → R4 reads 4.
